// File: rtl/decompress_controller.sv
// rtl/decompress_controller.sv - fetches run pairs from RAM and sequences decompress_handler
module decompress_controller #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] srcBase,
  input  logic [15:0] pairCount,
  input  logic [31:0] dstByteIndx,
  input  logic [2:0]  dstBitIndx,
  output logic [15:0] ramAddress,
  output logic        ramReadSignal,
  input  logic [7:0]  ramDataIn,
  output logic        ramOwner,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic        work,
  output logic        working,
  output logic [31:0] byteIndx,
  output logic [2:0]  bitIndx,
  input  logic        handlerDone,
  input  logic [31:0] newByteIndx,
  input  logic [2:0]  newBitIndx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] finalByteIndx,
  output logic [2:0]  finalBitIndx
);

  typedef enum logic [2:0] {IDLE, RD1, RD1W, RD2, RD2W, HANDLE, UPDATE, FINISH} state_t;

  localparam logic [15:0] HC_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] src_q, cnt_q, pair_idx_q, hc_q, ram_address_q;
  logic        ram_read_q, ram_owner_q, work_q, busy_q, done_q, error_q;
  logic [7:0]  in1_q, in2_q;
  logic [31:0] byte_q, final_byte_q;
  logic [2:0]  bit_q, final_bit_q;

  logic [15:0] next_idx_d, next_addr_d;
  logic        empty_run_d;

  assign next_idx_d  = pair_idx_q + 16'd1;
  assign next_addr_d = src_q + (next_idx_d << 1);
  // in2 is still on the RAM bus in RD2W, so test it directly
  assign empty_run_d = ({1'b0, in1_q[6:0]} + {1'b0, ramDataIn[6:0]}) == 8'd0;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      src_q         <= '0;
      cnt_q         <= '0;
      pair_idx_q    <= '0;
      hc_q          <= '0;
      ram_address_q <= '0;
      ram_read_q    <= 1'b0;
      ram_owner_q   <= 1'b1;
      work_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      in1_q         <= '0;
      in2_q         <= '0;
      byte_q        <= '0;
      bit_q         <= '0;
      final_byte_q  <= '0;
      final_bit_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          src_q      <= srcBase;
          cnt_q      <= pairCount;
          byte_q     <= dstByteIndx;
          bit_q      <= dstBitIndx;
          pair_idx_q <= '0;
          error_q    <= 1'b0;
          busy_q     <= 1'b1;
          if (pairCount == 16'd0) begin
            state_q <= FINISH;
          end else begin
            ram_address_q <= srcBase;
            ram_read_q    <= 1'b1;
            ram_owner_q   <= 1'b1;
            state_q       <= RD1;
          end
        end
        RD1: begin
          ram_read_q <= 1'b0;
          state_q    <= RD1W;
        end
        RD1W: begin
          in1_q         <= ramDataIn;
          ram_address_q <= ram_address_q + 16'd1;
          ram_read_q    <= 1'b1;
          state_q       <= RD2;
        end
        RD2: begin
          ram_read_q <= 1'b0;
          state_q    <= RD2W;
        end
        RD2W: begin
          in2_q <= ramDataIn;
          hc_q  <= '0;
          if (empty_run_d) begin
            state_q <= UPDATE;
          end else begin
            ram_owner_q <= 1'b0;
            work_q      <= 1'b1;
            state_q     <= HANDLE;
          end
        end
        HANDLE: begin
          // the first two cycles may still see done left high by the previous pair
          if (hc_q >= 16'd2 && handlerDone) begin
            byte_q      <= newByteIndx;
            bit_q       <= newBitIndx;
            work_q      <= 1'b0;
            ram_owner_q <= 1'b1;
            state_q     <= UPDATE;
          end else if (hc_q == HC_LAST) begin
            error_q     <= 1'b1;
            work_q      <= 1'b0;
            ram_owner_q <= 1'b1;
            state_q     <= FINISH;
          end else begin
            hc_q <= hc_q + 16'd1;
          end
        end
        UPDATE: begin
          pair_idx_q <= next_idx_d;
          if (next_idx_d == cnt_q) begin
            state_q <= FINISH;
          end else begin
            ram_address_q <= next_addr_d;
            ram_read_q    <= 1'b1;
            state_q       <= RD1;
          end
        end
        FINISH: begin
          final_byte_q <= byte_q;
          final_bit_q  <= bit_q;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ramAddress    = ram_address_q;
  assign ramReadSignal = ram_read_q;
  assign ramOwner      = ram_owner_q;
  assign in1           = in1_q;
  assign in2           = in2_q;
  assign work          = work_q;
  assign working       = work_q;
  assign byteIndx      = byte_q;
  assign bitIndx       = bit_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign finalByteIndx = final_byte_q;
  assign finalBitIndx  = final_bit_q;

endmodule

// File: tb/tb_decompress_controller.sv
// tb/tb_decompress_controller.sv - randomized bench with a transaction-level model of the controller
module tb_decompress_controller;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] srcBase = '0;
  logic [15:0] pairCount = '0;
  logic [31:0] dstByteIndx = '0;
  logic [2:0]  dstBitIndx = '0;
  logic [15:0] ramAddress;
  logic        ramReadSignal;
  logic [7:0]  ramDataIn = '0;
  logic        ramOwner;
  logic [7:0]  in1, in2;
  logic        work, working;
  logic [31:0] byteIndx;
  logic [2:0]  bitIndx;
  logic        handlerDone = 1'b0;
  logic [31:0] newByteIndx = '0;
  logic [2:0]  newBitIndx = '0;
  logic        busy, done, error;
  logic [31:0] finalByteIndx;
  logic [2:0]  finalBitIndx;

  decompress_controller #(.TIMEOUT(64)) dut (
    .clk(clk), .RST(RST), .start(start), .srcBase(srcBase), .pairCount(pairCount),
    .dstByteIndx(dstByteIndx), .dstBitIndx(dstBitIndx), .ramAddress(ramAddress),
    .ramReadSignal(ramReadSignal), .ramDataIn(ramDataIn), .ramOwner(ramOwner),
    .in1(in1), .in2(in2), .work(work), .working(working), .byteIndx(byteIndx),
    .bitIndx(bitIndx), .handlerDone(handlerDone), .newByteIndx(newByteIndx),
    .newBitIndx(newBitIndx), .busy(busy), .done(done), .error(error),
    .finalByteIndx(finalByteIndx), .finalBitIndx(finalBitIndx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] i1; logic [7:0] i2; logic [31:0] b; logic [2:0] bt; int ncyc; } pres_t;
  typedef struct { logic [31:0] b; logic [2:0] bt; int dly; bit hang; } rsp_t;

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_wcycles = 0, last_lat = 0;
  logic [7:0]  mem [65536];
  logic [31:0] rb [16];
  logic [2:0]  rbit [16];
  int          rdly [16];
  logic [15:0] exp_reads [$];
  logic [15:0] obs_reads [$];
  pres_t       exp_work [$];
  pres_t       obs_work [$];
  rsp_t        hq [$];
  logic [31:0] exp_fb = '0;
  logic [2:0]  exp_fbt = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  always @(posedge clk) cyc++;

  // RAM: a strobe seen in one cycle returns data in the next; garbage otherwise
  bit          rd_pend = 1'b0;
  logic [15:0] rd_addr_pend = '0;
  always @(negedge clk) begin
    if (rd_pend) ramDataIn = mem[rd_addr_pend];
    else ramDataIn = 8'($urandom);
    rd_pend = RST && ramReadSignal;
    rd_addr_pend = ramAddress;
  end

  // Handler: done stays high from the previous pair until the 3rd cycle of new work
  int   wcnt = 0;
  rsp_t hcur;
  always @(negedge clk) begin
    if (!RST) wcnt = 0;
    else if (work) begin
      wcnt++;
      if (wcnt == 1) begin
        if (hq.size() > 0) hcur = hq.pop_front();
        else hcur = '{32'd0, 3'd0, 1000, 1'b1};
      end
      if (wcnt == 3) handlerDone = 1'b0;
      if (!hcur.hang && wcnt == hcur.dly) begin
        handlerDone = 1'b1;
        newByteIndx = hcur.b;
        newBitIndx  = hcur.bt;
      end
    end else wcnt = 0;
  end

  bit    work_prev = 1'b0;
  int    wcycles = 0;
  pres_t cur;
  always @(negedge clk) begin
    if (!RST) begin
      work_prev = 1'b0;
      wcycles = 0;
    end else begin
      if (ramReadSignal) begin
        obs_reads.push_back(ramAddress);
        if (exp_reads.size() == 0) flag("rd_unexpected");
        else chk("rd_addr", ramAddress, exp_reads.pop_front());
        chk("rd_owner", ramOwner, 1);
        chk("rd_busy", busy, 1);
      end
      if (work) begin
        if (!work_prev) begin
          if (exp_work.size() == 0) begin
            flag("work_unexpected");
            cur = '{8'd0, 8'd0, 32'd0, 3'd0, 0};
          end else cur = exp_work.pop_front();
          obs_work.push_back('{in1, in2, byteIndx, bitIndx, 0});
          wcycles = 0;
        end
        wcycles++;
        chk("in1", in1, cur.i1);
        chk("in2", in2, cur.i2);
        chk("byteIndx", byteIndx, cur.b);
        chk("bitIndx", bitIndx, cur.bt);
        chk("working", working, 1);
        chk("handle_owner", ramOwner, 0);
        chk("handle_rd", ramReadSignal, 0);
        chk("handle_busy", busy, 1);
      end else if (work_prev) begin
        chk("work_len", wcycles, cur.ncyc);
        last_wcycles = wcycles;
      end
      work_prev = work;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("final_byte", finalByteIndx, exp_fb);
        chk("final_bit", finalBitIndx, exp_fbt);
        chk("error", error, exp_err);
        chk("done_busy", busy, 0);
        chk("done_owner", ramOwner, 1);
      end
    end
  end

  task automatic run_job(input logic [15:0] src, input int n, input logic [31:0] db0,
                         input logic [2:0] bt0, input int hang_pair, input int abort_reads,
                         input bit spurious);
    logic [31:0] cb;
    logic [2:0]  cbt;
    bit          err, fin;
    logic [15:0] a, a2;
    int          dc0, s, k;
    exp_reads.delete(); exp_work.delete(); hq.delete(); obs_reads.delete(); obs_work.delete();
    cb = db0; cbt = bt0; err = 1'b0;
    for (int i = 0; i < n && !err; i++) begin
      a = src + 16'(2 * i);
      a2 = a + 16'd1;
      exp_reads.push_back(a);
      exp_reads.push_back(a2);
      if ((int'(mem[a][6:0]) + int'(mem[a2][6:0])) != 0) begin
        if (i == hang_pair) begin
          exp_work.push_back('{mem[a], mem[a2], cb, cbt, 64});
          hq.push_back('{32'd0, 3'd0, 0, 1'b1});
          err = 1'b1;
        end else begin
          exp_work.push_back('{mem[a], mem[a2], cb, cbt, rdly[i]});
          hq.push_back('{rb[i], rbit[i], rdly[i], 1'b0});
          cb = rb[i];
          cbt = rbit[i];
        end
      end
    end
    exp_fb = cb; exp_fbt = cbt; exp_err = err;
    dc0 = done_cnt;
    @(negedge clk); #1;
    srcBase = src; pairCount = 16'(n); dstByteIndx = db0; dstBitIndx = bt0;
    start = 1'b1; s = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    fin = 1'b0;
    for (k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk); #1;
      if (spurious && k == 2) begin
        start = 1'b1; srcBase = ~src; pairCount = 16'd9; dstByteIndx = ~db0;
      end
      if (spurious && k == 3) start = 1'b0;
      if (abort_reads > 0 && obs_reads.size() >= abort_reads) begin
        RST = 1'b0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", ramOwner, 1);
        chk("rst_rd", ramReadSignal, 0);
        chk("rst_addr", ramAddress, 0);
        chk("rst_done", done, 0);
        chk("rst_work", work, 0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_idle", busy, 0);
        fin = 1'b1;
      end else if (done_cnt != dc0) fin = 1'b1;
    end
    if (!fin) flag("job_timeout");
    last_lat = done_cyc - s;
    if (abort_reads == 0) begin
      chk("done_count", done_cnt - dc0, 1);
      chk("reads_left", exp_reads.size(), 0);
      chk("work_left", exp_work.size(), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("final_hold", finalByteIndx, exp_fb);
      chk("error_hold", error, exp_err);
      chk("done_once", done_cnt - dc0, 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_owner", ramOwner, 1);
    chk("reset_rd", ramReadSignal, 0);
    chk("reset_work", {work, working}, 0);
    chk("reset_in", {in1, in2}, 0);
    chk("reset_idx", byteIndx, 0);
    chk("reset_final", finalByteIndx, 0);
    @(negedge clk);
    RST = 1'b1;

    mem[16'h10] = 8'h83; mem[16'h11] = 8'h05;
    rb[0] = 32'd1; rbit[0] = 3'd7; rdly[0] = 6;
    run_job(16'h0010, 1, 32'd0, 3'd7, -1, 0, 1'b0);
    chk("t1_nreads", obs_reads.size(), 2);
    chk("t1_rd0", obs_reads[0], 16'h0010);
    chk("t1_rd1", obs_reads[1], 16'h0011);
    chk("t1_npres", obs_work.size(), 1);
    chk("t1_in1", obs_work[0].i1, 8'h83);
    chk("t1_in2", obs_work[0].i2, 8'h05);
    chk("t1_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'd1, 1'b0, 3'd7});

    mem[16'h20] = 8'h81; mem[16'h21] = 8'h02; mem[16'h22] = 8'h03;
    mem[16'h23] = 8'h10; mem[16'h24] = 8'h84; mem[16'h25] = 8'h01;
    rb[0] = 32'd2; rbit[0] = 3'd3; rdly[0] = 5;
    rb[1] = 32'd4; rbit[1] = 3'd0; rdly[1] = 9;
    rb[2] = 32'd5; rbit[2] = 3'd6; rdly[2] = 4;
    run_job(16'h0020, 3, 32'd0, 3'd7, -1, 0, 1'b1);
    chk("t2_nreads", obs_reads.size(), 6);
    chk("t2_p1_byte", obs_work[1].b, 32'd2);
    chk("t2_p1_bit", obs_work[1].bt, 3'd3);
    chk("t2_p2_byte", obs_work[2].b, 32'd4);
    chk("t2_p2_bit", obs_work[2].bt, 3'd0);
    chk("t2_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'd5, 1'b0, 3'd6});

    run_job(16'h0030, 0, 32'h1234, 3'd5, -1, 0, 1'b0);
    chk("t3_latency", last_lat, 2);
    chk("t3_nreads", obs_reads.size(), 0);
    chk("t3_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'h1234, 1'b0, 3'd5});

    mem[16'h40] = 8'h00; mem[16'h41] = 8'h80; mem[16'h42] = 8'h05; mem[16'h43] = 8'h01;
    rb[1] = 32'd9; rbit[1] = 3'd2; rdly[1] = 7;
    run_job(16'h0040, 2, 32'd3, 3'd4, -1, 0, 1'b0);
    chk("t4_nreads", obs_reads.size(), 4);
    chk("t4_npres", obs_work.size(), 1);
    chk("t4_in1", obs_work[0].i1, 8'h05);
    chk("t4_idx", {obs_work[0].b, 1'b0, obs_work[0].bt}, {32'd3, 1'b0, 3'd4});
    chk("t4_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'd9, 1'b0, 3'd2});

    mem[16'hFFFF] = 8'h02; mem[16'h0000] = 8'h03;
    rb[0] = 32'd7; rbit[0] = 3'd1; rdly[0] = 4;
    run_job(16'hFFFF, 1, 32'd0, 3'd7, -1, 0, 1'b0);
    chk("t5_rd0", obs_reads[0], 16'hFFFF);
    chk("t5_rd1", obs_reads[1], 16'h0000);

    mem[16'h50] = 8'h10; mem[16'h51] = 8'h01; mem[16'h52] = 8'h02; mem[16'h53] = 8'h02;
    run_job(16'h0050, 2, 32'h77, 3'd2, 0, 0, 1'b0);
    chk("t6_error", error, 1);
    chk("t6_handle_cycles", last_wcycles, 64);
    chk("t6_nreads", obs_reads.size(), 2);
    chk("t6_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'h77, 1'b0, 3'd2});

    mem[16'h60] = 8'h11; mem[16'h61] = 8'h22; mem[16'h62] = 8'h33; mem[16'h63] = 8'h44;
    rb[0] = 32'h100; rbit[0] = 3'd1; rdly[0] = 5;
    rb[1] = 32'h200; rbit[1] = 3'd6; rdly[1] = 6;
    run_job(16'h0060, 2, 32'd10, 3'd0, -1, 2, 1'b0);
    run_job(16'h0060, 2, 32'd10, 3'd0, -1, 0, 1'b0);
    chk("t7_error", error, 0);
    chk("t7_final", {finalByteIndx, 1'b0, finalBitIndx}, {32'h200, 1'b0, 3'd6});

    for (int j = 0; j < 40; j++) begin
      logic [15:0] src, a, a2;
      int n, hp;
      src = 16'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        a = src + 16'(2 * i);
        a2 = a + 16'd1;
        if ($urandom_range(0, 3) == 0) begin
          mem[a]  = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
          mem[a2] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
        end else begin
          mem[a]  = 8'($urandom);
          mem[a2] = 8'($urandom);
        end
        rb[i] = $urandom;
        rbit[i] = 3'($urandom);
        rdly[i] = $urandom_range(4, 12);
      end
      hp = -1;
      if ($urandom_range(0, 9) == 0) begin
        hp = $urandom_range(0, n - 1);
        a = src + 16'(2 * hp);
        mem[a] = mem[a] | 8'h01;
      end
      run_job(src, n, $urandom, 3'($urandom), hp, 0, (j % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
